// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serializes one {1'b1, addr[6:0], data[7:0]} write frame per accepted command.
// Pins are fully registered and framed so that a 2-flop synchronized peripheral sees clean, well-spaced edges.
module spi_controller #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   div_reg, div_next;
    logic [3:0]      bit_reg, bit_next;
    logic [GW-1:0]   gap_reg, gap_next;
    logic            half_reg, half_next;
    logic [15:0]     shift_reg, shift_next;
    logic            ncs_reg, ncs_next;
    logic            sclk_reg, sclk_next;
    logic            copi_reg, copi_next;
    logic            done_reg, done_next;
    logic            busy_reg, busy_next;
    logic            ready_reg, ready_next;
    logic            div_end;

    assign div_end = (div_reg == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            div_reg   <= '0;
            bit_reg   <= '0;
            gap_reg   <= '0;
            half_reg  <= 1'b0;
            shift_reg <= '0;
            ncs_reg   <= 1'b1;
            sclk_reg  <= 1'b0;
            copi_reg  <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
            gap_reg   <= gap_next;
            half_reg  <= half_next;
            shift_reg <= shift_next;
            ncs_reg   <= ncs_next;
            sclk_reg  <= sclk_next;
            copi_reg  <= copi_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
            ready_reg <= ready_next;
        end
    end

    // Output registers are loaded with the values belonging to the state being entered,
    // so every pin changes exactly on the transition edge.
    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        gap_next   = gap_reg;
        half_next  = half_reg;
        shift_next = shift_reg;
        ncs_next   = ncs_reg;
        sclk_next  = sclk_reg;
        copi_next  = copi_reg;
        done_next  = 1'b0;
        busy_next  = busy_reg;
        ready_next = ready_reg;

        case (state_reg)
            IDLE: begin
                ncs_next   = 1'b1;
                sclk_next  = 1'b0;
                busy_next  = 1'b0;
                ready_next = 1'b1;
                if (cmd_valid && ready_reg) begin
                    state_next = SETUP;
                    shift_next = {1'b1, cmd_addr, cmd_data};
                    copi_next  = 1'b1;
                    ncs_next   = 1'b0;
                    busy_next  = 1'b1;
                    ready_next = 1'b0;
                    div_next   = '0;
                end
            end
            SETUP: begin
                div_next = div_reg + 1'b1;
                if (div_end) begin
                    state_next = SHIFT;
                    div_next   = '0;
                    bit_next   = 4'd15;
                    half_next  = 1'b0;
                    sclk_next  = 1'b1;
                end
            end
            SHIFT: begin
                div_next = div_reg + 1'b1;
                if (div_end) begin
                    div_next = '0;
                    if (!half_reg) begin
                        // Falling edge: present the next bit; the last bit stays on copi.
                        half_next = 1'b1;
                        sclk_next = 1'b0;
                        if (bit_reg != 4'd0) begin
                            shift_next = {shift_reg[14:0], 1'b0};
                            copi_next  = shift_reg[14];
                        end
                    end else if (bit_reg == 4'd0) begin
                        state_next = HOLD;
                    end else begin
                        bit_next  = bit_reg - 4'd1;
                        half_next = 1'b0;
                        sclk_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                div_next = div_reg + 1'b1;
                if (div_end) begin
                    state_next = GAP;
                    div_next   = '0;
                    gap_next   = GW'(1);
                    ncs_next   = 1'b1;
                    done_next  = 1'b1;
                end
            end
            GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    ready_next = 1'b1;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd_ready = ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign sclk      = sclk_reg;
    assign copi      = copi_reg;
    assign ncs       = ncs_reg;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: a default instance and a CLK_DIV=2/GAP_CYCLES=1 instance,
// each observed by a pin-level SPI receiver model that decodes write frames into a register image.
module tb_spi_controller;

    logic       clk = 1'b0;
    logic [1:0] rst_n = 2'b11;
    logic [1:0] cmd_valid = 2'b00;
    logic [6:0] cmd_addr [2];
    logic [7:0] cmd_data [2];
    logic [1:0] cmd_ready, busy, done, sclk, copi, ncs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spi_controller u_dut_a (
        .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_addr(cmd_addr[0]), .cmd_data(cmd_data[0]), .busy(busy[0]), .done(done[0]),
        .sclk(sclk[0]), .copi(copi[0]), .ncs(ncs[0])
    );

    spi_controller #(.CLK_DIV(2), .GAP_CYCLES(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_addr(cmd_addr[1]), .cmd_data(cmd_data[1]), .busy(busy[1]), .done(done[1]),
        .sclk(sclk[1]), .copi(copi[1]), .ncs(ncs[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Pin-level monitor / receiver model, sampled on the falling clk edge.
    int          cyc = 0;
    logic [1:0]  p_ncs = 2'b11, p_sclk = 2'b00, p_copi = 2'b00;
    int          edges [2], low_cnt [2], high_run [2], done_cnt [2], acc_cnt [2];
    int          acc_cyc [2], acc_gap [2], done_cyc [2], last_high [2], frames [2];
    int          last_edges [2], last_low [2], copi_bad [2];
    logic [15:0] rx [2];
    logic [15:0] hist [2][64];
    logic [7:0]  regs [2][128];

    initial begin
        for (int d = 0; d < 2; d++) begin
            edges[d] = 0; low_cnt[d] = 0; high_run[d] = 0; done_cnt[d] = 0; acc_cnt[d] = 0;
            acc_cyc[d] = 0; acc_gap[d] = 0; done_cyc[d] = 0; last_high[d] = 0; frames[d] = 0;
            last_edges[d] = 0; last_low[d] = 0; copi_bad[d] = 0; rx[d] = '0;
            for (int r = 0; r < 128; r++) regs[d][r] = 8'h00;
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (cmd_valid[d] && cmd_ready[d]) begin
                acc_gap[d] = cyc - acc_cyc[d];
                acc_cyc[d] = cyc;
                acc_cnt[d]++;
            end
            if (done[d]) begin
                done_cnt[d]++;
                done_cyc[d] = cyc;
            end
            if (!ncs[d]) begin
                if (p_ncs[d]) begin
                    last_high[d] = high_run[d];
                    edges[d] = 0;
                    low_cnt[d] = 0;
                    rx[d] = '0;
                end
                low_cnt[d]++;
                if (sclk[d] && !p_sclk[d]) begin
                    edges[d]++;
                    rx[d] = {rx[d][14:0], copi[d]};
                    if (copi[d] !== p_copi[d]) copi_bad[d]++;
                end
            end else begin
                if (!p_ncs[d]) begin
                    last_edges[d] = edges[d];
                    last_low[d] = low_cnt[d];
                    hist[d][frames[d] % 64] = rx[d];
                    frames[d]++;
                    if (edges[d] == 16 && rx[d][15]) regs[d][rx[d][14:8]] = rx[d][7:0];
                    high_run[d] = 0;
                end
                high_run[d]++;
            end
            p_ncs[d] = ncs[d];
            p_sclk[d] = sclk[d];
            p_copi[d] = copi[d];
        end
    end

    task automatic wait_ready(input int d);
        int n = 0;
        while (!cmd_ready[d] && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) check("ready_timeout", 32'(n), 32'(0));
    endtask

    task automatic issue(input int d, input logic [6:0] a, input logic [7:0] v);
        @(posedge clk); #1;
        cmd_addr[d] = a;
        cmd_data[d] = v;
        cmd_valid[d] = 1'b1;
        wait_ready(d);
        @(posedge clk); #1;
        cmd_valid[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        while (!done[d] && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) check("done_timeout", 32'(n), 32'(0));
        @(negedge clk); #1;
    endtask

    int   a0, d0, f0;
    logic ready_seen;

    initial begin
        cmd_addr[0] = '0; cmd_data[0] = '0; cmd_addr[1] = '0; cmd_data[1] = '0;
        #2 rst_n = 2'b00;
        #1;
        check("rst_ncs", ncs[0], 1'b1);
        check("rst_sclk", sclk[0], 1'b0);
        check("rst_copi", copi[0], 1'b0);
        check("rst_done", done[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        check("rst_ready", cmd_ready[0], 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 2'b11;
        repeat (2) @(posedge clk); #1;
        check("idle_ready", cmd_ready[0], 1'b1);

        // Single frame 0x00 <- 0xFF
        d0 = done_cnt[0];
        issue(0, 7'h00, 8'hFF);
        check("t1_busy", busy[0], 1'b1);
        check("t1_ncs_low", ncs[0], 1'b0);
        check("t1_copi_b15", copi[0], 1'b1);
        wait_done(0);
        check("t1_bits", last_edges[0] == 16 ? hist[0][(frames[0] - 1) % 64] : 16'hxxxx, 16'h80FF);
        check("t1_edges", last_edges[0], 16);
        check("t1_ncs_low_cycles", last_low[0], 136);
        check("t1_acc_to_done", done_cyc[0] - acc_cyc[0], 137);
        check("t1_done_pulses", done_cnt[0] - d0, 1);
        check("t1_reg00", regs[0][0], 8'hFF);

        // Register writes through the receiver model
        issue(0, 7'h04, 8'h80); wait_done(0);
        issue(0, 7'h00, 8'h01); wait_done(0);
        issue(0, 7'h02, 8'h01); wait_done(0);
        check("t2_reg04", regs[0][4], 8'h80);
        check("t2_reg00", regs[0][0], 8'h01);
        check("t2_reg02", regs[0][2], 8'h01);

        // Back-to-back with cmd_valid held high
        f0 = frames[0];
        @(posedge clk); #1;
        cmd_addr[0] = 7'h11; cmd_data[0] = 8'hA5; cmd_valid[0] = 1'b1;
        wait_ready(0);
        @(posedge clk); #1;
        cmd_addr[0] = 7'h12; cmd_data[0] = 8'h5A;
        wait_ready(0);
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        wait_done(0);
        check("t3_frame1", hist[0][f0 % 64], 16'h91A5);
        check("t3_frame2", hist[0][(f0 + 1) % 64], 16'h925A);
        check("t3_accept_spacing", acc_gap[0], 141);
        check("t3_ncs_high_between", last_high[0], 5);

        // Mid-frame command changes are ignored
        a0 = acc_cnt[0];
        ready_seen = 1'b0;
        issue(0, 7'h15, 8'h3C);
        repeat (40) @(posedge clk); #1;
        cmd_addr[0] = 7'h6A; cmd_data[0] = 8'hC3; cmd_valid[0] = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            ready_seen |= cmd_ready[0];
        end
        cmd_valid[0] = 1'b0;
        wait_done(0);
        check("t4_ready_low", ready_seen, 1'b0);
        check("t4_bits", hist[0][(frames[0] - 1) % 64], 16'h953C);
        check("t4_accepts", acc_cnt[0] - a0, 1);

        // Reset after the 7th rising sclk edge
        d0 = done_cnt[0];
        issue(0, 7'h06, 8'hAA);
        a0 = 0;
        while (!(edges[0] == 7 && !ncs[0]) && a0 < 2000) begin
            @(posedge clk); #1;
            a0++;
        end
        check("t5_reached_edge7", edges[0], 7);
        rst_n[0] = 1'b0;
        #1;
        check("t5_ncs", ncs[0], 1'b1);
        check("t5_sclk", sclk[0], 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_no_done", done_cnt[0] - d0, 0);
        check("t5_reg06_kept", regs[0][6], 8'h00);
        issue(0, 7'h06, 8'hAA);
        wait_done(0);
        check("t5_reg06_written", regs[0][6], 8'hAA);

        // CLK_DIV=2, GAP_CYCLES=1 instance
        issue(1, 7'h01, 8'h55);
        wait_done(1);
        check("t6_ncs_low_cycles", last_low[1], 68);
        check("t6_edges", last_edges[1], 16);
        check("t6_acc_to_done", done_cyc[1] - acc_cyc[1], 69);
        check("t6_reg01", regs[1][1], 8'h55);

        check("copi_stable_a", copi_bad[0], 0);
        check("copi_stable_b", copi_bad[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
